itcm_byte_loader: RTL
=====================

ITCM_BYTE_LOADER -- requirements
Module: itcm_byte_loader

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 12, ITCM word-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 64, ITCM word width; legal values are multiples of 8 only.
REQ-003 SHALL have port clk  input  1  clock; all state changes on the rising edge.
REQ-004 SHALL have port tb_rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  input  1  load request, sampled only in IDLE.
REQ-006 SHALL have port len_words  input  ADDR_WIDTH+1  number of words to load, sampled with start; legal range 0..2**ADDR_WIDTH.
REQ-007 SHALL have port abort  input  1  cancel the load in progress.
REQ-008 SHALL have port s_valid  input  1  byte-stream valid.
REQ-009 SHALL have port s_data  input  8  byte-stream data.
REQ-010 SHALL have port s_ready  output  1  byte-stream ready.
REQ-011 SHALL have port ram_addr  output  ADDR_WIDTH  ITCM address.
REQ-012 SHALL have port ram_wr_data  output  DATA_WIDTH  ITCM write data.
REQ-013 SHALL have port ram_wr_en  output  1  ITCM write strobe.
REQ-014 SHALL have port busy  output  1  load in progress.
REQ-015 SHALL have port done  output  1  one-cycle completion pulse.
REQ-016 SHALL have port words_written  output  ADDR_WIDTH+1  words committed in the current or last load.
REQ-017 SHALL have port checksum  output  8  modulo-256 sum of all bytes accepted in the current or last load.

Function
REQ-018 SHALL implement a state machine with states IDLE, COLLECT, WRITE and FIN.
REQ-019 IDLE, on start with len_words==0 SHALL go to FIN.
REQ-020 IDLE, on start with len_words!=0 SHALL latch len_words, clear words_written, checksum and the byte index, and go to COLLECT.
REQ-021 SHALL assert s_ready only in COLLECT.
REQ-022 SHALL treat a byte as accepted on a cycle where s_valid and s_ready are both 1.
REQ-023 Each accepted byte k (k = 0..DATA_WIDTH/8-1) SHALL be stored in word bits [8k+7:8k], little-endian.
REQ-024 Each accepted byte SHALL be added to checksum, wrapping modulo 256.
REQ-025 The byte index SHALL increment on each accepted byte.
REQ-026 Acceptance of the last byte of a word SHALL move the machine to WRITE on the next edge.
REQ-027 s_valid low in COLLECT SHALL hold all state (no timeout).
REQ-028 WRITE SHALL last exactly one cycle.
REQ-029 In WRITE, ram_wr_en SHALL be 1, ram_addr SHALL equal words_written[ADDR_WIDTH-1:0], and ram_wr_data SHALL be the assembled word.
REQ-030 At the end of WRITE, words_written SHALL increment and the byte index SHALL clear.
REQ-031 From WRITE, the machine SHALL go to FIN if the incremented count equals the latched length, else to COLLECT.
REQ-032 FIN SHALL assert done for one cycle, then go to IDLE.
REQ-033 busy SHALL be 1 in COLLECT and WRITE, and 0 otherwise.
REQ-034 ram_wr_en SHALL be 0 outside WRITE.
REQ-035 ram_addr and ram_wr_data SHALL hold their last values outside WRITE.
REQ-036 With len_words == 2**ADDR_WIDTH, the load SHALL write addresses 0..2**ADDR_WIDTH-1 and words_written SHALL reach 2**ADDR_WIDTH without wrap.
REQ-037 abort in COLLECT or WRITE SHALL take precedence over all other events in that cycle.
REQ-038 On abort, the machine SHALL return to IDLE with no write in that cycle and no done pulse.
REQ-039 On abort, the partial word SHALL be discarded, and words_written and checksum SHALL keep their values.
REQ-040 start outside IDLE SHALL be ignored.
REQ-041 abort in IDLE or FIN SHALL be ignored.
REQ-042 The ITCM write SHALL be issued with zero extra latency: the data is valid in the same cycle as ram_wr_en, matching the single-port RAM write timing.

Reset
REQ-043 On tb_rst high, the machine SHALL enter IDLE immediately, asynchronously.
REQ-044 During reset, s_ready, ram_wr_en, busy and done SHALL be 0.
REQ-045 During reset, ram_addr, ram_wr_data, words_written, checksum, the byte index and the latched length SHALL be 0.
REQ-046 Reset asserted mid-load SHALL abandon the load; no partial write SHALL complete.
REQ-047 After release, the block SHALL wait for a new start.

Verification
REQ-048 Single word: start, len_words=1, bytes 01..08 back-to-back -> one write at addr 0 with data 0x0807060504030201; done pulse 2 cycles after the last byte; checksum 0x24.
REQ-049 Back-pressure gaps: len_words=3, s_valid toggling 1/0, 24 bytes -> writes at addr 0,1,2 in order; s_ready 0 during each WRITE cycle; words_written=3.
REQ-050 Zero length: start with len_words=0 -> no ram_wr_en, done high the cycle after start, busy never 1.
REQ-051 Full depth: len_words=4096, byte value = index mod 256 -> 4096 writes, last at addr 0xFFF; words_written=4096; RAM read-back of every address matches.
REQ-052 Abort: abort after byte 5 of word 2 (len_words=4) -> no further writes, words_written=2, done never asserted, next start loads correctly from addr 0.
REQ-053 Reset mid-load: tb_rst pulse during COLLECT -> all outputs 0 immediately, no write, s_ready 0 until a new start.

Source files
------------

// File: rtl/itcm_byte_loader.sv
// itcm_byte_loader: packs a byte stream little-endian into DATA_WIDTH-bit
// words and writes them to consecutive ITCM addresses starting at 0.
// The RAM write strobe, address and data are combinational from the WRITE
// state, so they line up in the same cycle for a single-port RAM.
module itcm_byte_loader #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  tb_rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   len_words,
  input  logic                  abort,
  input  logic                  s_valid,
  input  logic [7:0]            s_data,
  output logic                  s_ready,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  output logic                  ram_wr_en,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   words_written,
  output logic [7:0]            checksum
);

  localparam int NB = DATA_WIDTH / 8;
  // Wide enough to hold NB itself, so non-power-of-two lane counts work.
  localparam int IW = $clog2(NB + 1);

  typedef enum logic [1:0] {IDLE, COLLECT, WRITE, FIN} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH:0]   len_q, len_d;
  logic [ADDR_WIDTH:0]   words_q, words_d;
  logic [7:0]            csum_q, csum_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;

  logic                  accept;
  logic                  last_byte;
  logic                  wr_fire;
  logic [ADDR_WIDTH:0]   words_inc;
  logic [NB-1:0]         lane_we;

  // abort masks s_ready so an aborted cycle never counts as a handshake.
  assign s_ready   = (state_q == COLLECT) && !abort;
  assign accept    = s_ready && s_valid;
  assign last_byte = (idx_q == IW'(NB - 1));
  assign wr_fire   = (state_q == WRITE) && !abort;
  assign words_inc = words_q + (ADDR_WIDTH + 1)'(1);

  // One write-enable per byte lane, selected by the current byte index.
  generate
    for (genvar gi = 0; gi < NB; gi++) begin : g_lane
      assign lane_we[gi] = accept && (idx_q == IW'(gi));
    end
  endgenerate

  // RAM port: live values during the write, held copies otherwise.
  assign ram_wr_en     = wr_fire;
  assign ram_addr      = wr_fire ? words_q[ADDR_WIDTH-1:0] : addr_q;
  assign ram_wr_data   = wr_fire ? word_q : wr_data_q;
  assign busy          = (state_q == COLLECT) || (state_q == WRITE);
  assign done          = (state_q == FIN);
  assign words_written = words_q;
  assign checksum      = csum_q;

  // Next-state and datapath update for the load sequencer.
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    words_d   = words_q;
    csum_d    = csum_q;
    idx_d     = idx_q;
    word_d    = word_q;
    addr_d    = addr_q;
    wr_data_d = wr_data_q;

    for (int i = 0; i < NB; i++) begin
      if (lane_we[i]) begin
        word_d[8*i +: 8] = s_data;
      end
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          if (len_words == '0) begin
            state_d = FIN;
          end else begin
            len_d   = len_words;
            words_d = '0;
            csum_d  = '0;
            idx_d   = '0;
            word_d  = '0;
            state_d = COLLECT;
          end
        end
      end
      COLLECT: begin
        if (abort) begin
          state_d = IDLE;
        end else if (accept) begin
          csum_d = csum_q + s_data;
          idx_d  = idx_q + IW'(1);
          if (last_byte) begin
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          addr_d    = words_q[ADDR_WIDTH-1:0];
          wr_data_d = word_q;
          words_d   = words_inc;
          idx_d     = '0;
          state_d   = (words_inc == len_q) ? FIN : COLLECT;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously by tb_rst.
  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      state_q   <= IDLE;
      len_q     <= '0;
      words_q   <= '0;
      csum_q    <= '0;
      idx_q     <= '0;
      word_q    <= '0;
      addr_q    <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      words_q   <= words_d;
      csum_q    <= csum_d;
      idx_q     <= idx_d;
      word_q    <= word_d;
      addr_q    <= addr_d;
      wr_data_q <= wr_data_d;
    end
  end

endmodule
